asyncram_wr_ctrl: RTL and testbench
===================================

Name: asyncram_wr_ctrl

Overview:
Write-side controller for the dual-clock 8x16 RAM, operating entirely in the wclk domain.
Accepts a valid/ready word stream and drives the RAM write port (we, waddr, din).
Maintains a wrap-bit write pointer and publishes it Gray-coded to the read side.
Synchronises the reader's Gray pointer to derive full, almost_full, fill level and a sticky overflow flag. Together with the RAM and a read-side controller, it forms an 8-deep asynchronous FIFO.

Parameters:
DW, 16, data width; matches RAM word width
AW, 3, RAM address width; depth = 2**AW = 8
SYNC_STAGES, 2, flop stages synchronising rptr_gray_async into wclk; legal values 2..3
AFULL_TH, 6, almost_full asserts when level >= AFULL_TH; legal range 1..2**AW

Ports:
wclk  in  1  write clock
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  upstream word valid
s_ready  out  1  controller can accept a word; = !full
s_data  in  DW  upstream word
we  out  1  RAM write enable; = s_valid & s_ready
waddr  out  AW  RAM write address; = wbin[AW-1:0]
din  out  DW  RAM write data; = s_data
wptr_gray  out  AW+1  registered Gray write pointer, to read domain
rptr_gray_async  in  AW+1  Gray read pointer from rdclk domain, unsynchronised
full  out  1  FIFO full (pessimistic)
almost_full  out  1  level >= AFULL_TH
level  out  AW+1  words written minus words known read, 0..8
ovf  out  1  sticky overflow: write attempted while full
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (rst=1, async):
  - wbin=0, wptr_gray=0; all sync flops=0.
  - ovf=0, full=0, almost_full=0, level=0, s_ready=1.
- Write pointer wbin (AW+1 bits, binary):
  - Increments by 1 on a wclk edge where we=1.
  - Wraps 15 -> 0 (MSB is the wrap bit); waddr therefore wraps 7 -> 0.
- wptr_gray is registered: wptr_gray <= next_wbin ^ (next_wbin >> 1).
  - Exactly one bit changes per increment.
  - No combinational path from it to the output port.
- we, waddr, din are combinational. The RAM captures the word on the same wclk edge that advances wbin, so write latency is 0 cycles at the port.
- Read-pointer synchroniser:
  - SYNC_STAGES-deep flop chain on rptr_gray_async; rsync = last stage.
  - No logic between stages.
- full = (wptr_gray == {~rsync[AW:AW-1], rsync[AW-2:0]}), combinational from registered values.
  - Asserts in the cycle after the 8th outstanding write.
  - Deasserts SYNC_STAGES wclk edges after the read side advances its pointer. This is pessimistic and never optimistic.
- level = wbin - gray2bin(rsync), modulo 2**(AW+1).
- almost_full = (level >= AFULL_TH).
- ovf behaviour:
  - Set on any wclk edge with s_valid=1 & full=1.
  - Cleared on an edge with ovf_clr=1.
  - If set and clear occur on the same edge, set wins.
  - A rejected word produces no we and no pointer change.
- Handshake:
  - Transfer occurs on an edge with s_valid & s_ready.
  - s_data may change freely when s_ready=0; the upstream source must hold s_data and s_valid until the transfer.
- Reset mid-burst: pointers return to 0 immediately and we drops. The read-side controller is reset by the same rst, so the FIFO is empty after reset.

Test Plan:
- Reset: assert rst with s_valid=1 -> we=0, waddr=0, wptr_gray=0, full=0, level=0, ovf=0, s_ready=1.
- Fill, rptr_gray_async=0: 8 back-to-back words 0xA000..0xA007 ->
  - waddr = 0..7; din matches each word.
  - wptr_gray sequence 1,3,2,6,7,5,4,C.
  - almost_full rises after the 6th write; full=1 and s_ready=0 after the 8th.
  - level=8.
- Overflow: while full, s_valid=1 for 3 cycles -> no we, wptr_gray stays 0xC, ovf=1.
  - ovf_clr pulse -> ovf=0.
  - ovf_clr together with another rejected attempt -> ovf stays 1.
- Drain visibility: from full, set rptr_gray_async=0x1 -> full stays 1 for exactly SYNC_STAGES edges, then full=0 and level=7.
  - One further write -> full=1 again and wptr_gray=0xD.
- Wrap: stream 20 words while rptr_gray_async tracks 4 words behind ->
  - waddr wraps 7 -> 0 twice; wbin wraps 15 -> 0.
  - full never asserts; level steady at 4.
- Reset mid-burst: assert rst after the 3rd write -> wptr_gray=0 and level=0 immediately (asynchronously).
  - After rst release, the next write goes to waddr=0.

Source files
------------

// File: rtl/asyncram_wr_ctrl.sv
// rtl/asyncram_wr_ctrl.sv - write-side controller of the 8-deep dual-clock FIFO
module asyncram_wr_ctrl #(
   parameter int DW          = 16,
   parameter int AW          = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AFULL_TH    = 6
) (
   input  logic          wclk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] din,
   output logic [AW:0]   wptr_gray,
   input  logic [AW:0]   rptr_gray_async,
   output logic          full,
   output logic          almost_full,
   output logic [AW:0]   level,
   output logic          ovf,
   input  logic          ovf_clr
);

   logic [AW:0] r_wbin;
   logic [AW:0] r_wptr_gray;
   logic [AW:0] r_sync [SYNC_STAGES];
   logic        r_ovf;

   logic [AW:0] w_rsync;
   logic [AW:0] w_rbin;
   logic [AW:0] w_wbin_next;
   logic [AW:0] w_level;
   logic        w_full;
   logic        w_we;

   assign w_rsync = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_rbin     = '0;
      w_rbin[AW] = w_rsync[AW];
      for (int i = AW - 1; i >= 0; i--)
         w_rbin[i] = w_rbin[i+1] ^ w_rsync[i];
   end

   // Full compare in Gray space: writer is one lap ahead of the last read pointer seen.
   assign w_full      = (r_wptr_gray == {~w_rsync[AW:AW-1], w_rsync[AW-2:0]});
   // rst gating keeps the RAM port quiet while the pointers are held at zero.
   assign w_we        = s_valid & ~w_full & ~rst;
   assign w_wbin_next = w_we ? r_wbin + 1'b1 : r_wbin;
   assign w_level     = r_wbin - w_rbin;

   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         r_wbin      <= '0;
         r_wptr_gray <= '0;
         r_ovf       <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++)
            r_sync[i] <= '0;
      end else begin
         r_wbin      <= w_wbin_next;
         r_wptr_gray <= w_wbin_next ^ (w_wbin_next >> 1);
         r_sync[0]   <= rptr_gray_async;
         for (int i = 1; i < SYNC_STAGES; i++)
            r_sync[i] <= r_sync[i-1];
         // A rejected attempt on the same edge as a clear must stay visible.
         if (s_valid & w_full)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   assign s_ready     = ~w_full;
   assign we          = w_we;
   assign waddr       = r_wbin[AW-1:0];
   assign din         = s_data;
   assign wptr_gray   = r_wptr_gray;
   assign full        = w_full;
   assign level       = w_level;
   assign almost_full = (w_level >= (AW+1)'(AFULL_TH));
   assign ovf         = r_ovf;

endmodule

// File: tb/tb_asyncram_wr_ctrl.sv
// tb/tb_asyncram_wr_ctrl.sv - directed bench for asyncram_wr_ctrl
module tb_asyncram_wr_ctrl;

   logic        wclk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic        we;
   logic [2:0]  waddr;
   logic [15:0] din;
   logic [3:0]  wptr_gray;
   logic [3:0]  rptr_gray_async = '0;
   logic        full;
   logic        almost_full;
   logic [3:0]  level;
   logic        ovf;
   logic        ovf_clr = 1'b0;

   int total = 0;
   int bad   = 0;
   int wb;
   logic [3:0] gseq [8];
   logic [3:0] tmp;

   asyncram_wr_ctrl #(.DW(16), .AW(3), .SYNC_STAGES(2), .AFULL_TH(6)) dut (
      .wclk(wclk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .we(we), .waddr(waddr), .din(din), .wptr_gray(wptr_gray),
      .rptr_gray_async(rptr_gray_async), .full(full), .almost_full(almost_full),
      .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 wclk = ~wclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge wclk);
      #1;
   endtask

   function automatic logic [3:0] g(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   initial begin
      gseq[0] = 4'h1; gseq[1] = 4'h3; gseq[2] = 4'h2; gseq[3] = 4'h6;
      gseq[4] = 4'h7; gseq[5] = 4'h5; gseq[6] = 4'h4; gseq[7] = 4'hC;

      // reset with s_valid high
      s_valid = 1'b1;
      s_data  = 16'h1234;
      edge1();
      edge1();
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wptr", wptr_gray, 0);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_ready", s_ready, 1);
      chk("rst_afull", almost_full, 0);
      s_valid = 1'b0;
      rst = 1'b0;
      edge1();

      // fill 8 words
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1;
         s_data  = 16'hA000 + 16'(k);
         #1;
         chk("fill_we", we, 1);
         chk("fill_waddr", waddr, k);
         chk("fill_din", din, 32'hA000 + k);
         edge1();
         chk("fill_gray", wptr_gray, gseq[k]);
         chk("fill_level", level, k + 1);
         chk("fill_afull", almost_full, (k + 1 >= 6) ? 1 : 0);
         chk("fill_full", full, (k == 7) ? 1 : 0);
      end
      chk("fill_ready", s_ready, 0);

      // overflow
      s_data = 16'hBEEF;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("ovf_we", we, 0);
         edge1();
         chk("ovf_gray", wptr_gray, 4'hC);
         chk("ovf_set", ovf, 1);
      end
      s_valid = 1'b0;
      ovf_clr = 1'b1;
      edge1();
      chk("ovf_clr", ovf, 0);
      s_valid = 1'b1;
      edge1();
      chk("ovf_set_wins", ovf, 1);
      chk("ovf_gray2", wptr_gray, 4'hC);
      s_valid = 1'b0;
      ovf_clr = 1'b0;
      edge1();
      chk("ovf_hold", ovf, 1);

      // drain visibility
      rptr_gray_async = 4'h1;
      #1;
      chk("drain_full0", full, 1);
      edge1();
      chk("drain_full1", full, 1);
      chk("drain_lvl1", level, 8);
      edge1();
      chk("drain_full2", full, 0);
      chk("drain_lvl2", level, 7);
      s_valid = 1'b1;
      s_data  = 16'hA008;
      #1;
      chk("drain_we", we, 1);
      edge1();
      s_valid = 1'b0;
      chk("drain_refull", full, 1);
      chk("drain_gray", wptr_gray, 4'hD);

      // wrap: preload synchroniser so level sits at 4, then track 4 behind
      wb = 9;
      rptr_gray_async = g(5);
      edge1();
      edge1();
      rptr_gray_async = g(6);
      edge1();
      chk("wrap_pre_lvl", level, 4);
      for (int k = 0; k < 20; k++) begin
         s_valid = 1'b1;
         s_data  = 16'hC000 + 16'(k);
         rptr_gray_async = g(wb - 2);
         #1;
         chk("wrap_we", we, 1);
         chk("wrap_waddr", waddr, wb % 8);
         edge1();
         wb = (wb + 1) % 16;
         chk("wrap_gray", wptr_gray, g(wb));
         chk("wrap_level", level, 4);
         chk("wrap_full", full, 0);
      end
      chk("wrap_wb", wb, 13);

      // reset mid-burst
      for (int k = 0; k < 3; k++) begin
         rptr_gray_async = g(wb - 2);
         edge1();
         wb = (wb + 1) % 16;
      end
      tmp = g(wb);
      chk("mid_gray_pre", wptr_gray, tmp);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_gray", wptr_gray, 0);
      chk("mid_level", level, 0);
      chk("mid_we", we, 0);
      rptr_gray_async = 4'h0;
      #1;
      rst = 1'b0;
      #1;
      chk("post_waddr", waddr, 0);
      chk("post_we", we, 1);
      edge1();
      s_valid = 1'b0;
      chk("post_gray", wptr_gray, 4'h1);
      chk("post_level", level, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
